// File: rtl/imem_access_ctrl.sv
// imem_access_ctrl: arbitrates the single port of the 32x32 instruction memory between fetch reads and loader writes.
// Latency: ack pulses 3 cycles after the grant edge (PARK, RD/WR, CAP/DONE); back-to-back accesses take 4 cycles.
// Backpressure: requesters hold req until ack; the loader wins ties unless fetch has waited FETCH_STARVE loader grants.
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-low reset
//   f_req/f_addr           fetch request and address; f_ack/f_data return the instruction
//   ld_req/ld_addr/ld_data loader write request; ld_ack pulses when the write is done
//   busy                   high whenever an access is in flight
//   mem_*                  pins of the instruction memory (write_en, mode, address, data_in, data_out)
module imem_access_ctrl #(
  parameter int AW           = 5,
  parameter int DW           = 32,
  parameter int PARK_ADDR    = 0,
  parameter int FETCH_STARVE = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_data,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ack,
  output logic          busy,
  output logic          mem_write_en,
  output logic          mem_mode,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out
);

  localparam int            SW         = $clog2(FETCH_STARVE + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(FETCH_STARVE);
  localparam logic [AW-1:0] PARK       = AW'(PARK_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PARK,
    S_RD,
    S_CAP,
    S_WR,
    S_DONE
  } state_t;

  state_t        state_q;
  logic          is_wr_q;
  logic [AW-1:0] tgt_q;
  logic [DW-1:0] wdat_q;
  logic [SW-1:0] starve_q;
  logic          f_ack_q;
  logic          ld_ack_q;
  logic          mem_we_q;
  logic          mem_mode_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_din_q;
  logic [DW-1:0] f_data_q;

  logic          grant_f_d;
  logic          grant_ld_d;
  logic [AW-1:0] park_f_d;
  logic [AW-1:0] park_ld_d;
  logic [SW-1:0] starve_ld_d;

  // The park address must differ from the target so the following RD/WR
  // cycle always presents an address event to the memory.
  always_comb begin
    grant_f_d   = f_req && (!ld_req || (starve_q == STARVE_MAX));
    grant_ld_d  = ld_req && !grant_f_d;
    park_f_d    = (f_addr == PARK) ? (PARK ^ AW'(1)) : PARK;
    park_ld_d   = (ld_addr == PARK) ? (PARK ^ AW'(1)) : PARK;
    starve_ld_d = '0;
    if (f_req) begin
      starve_ld_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      is_wr_q    <= 1'b0;
      tgt_q      <= '0;
      wdat_q     <= '0;
      starve_q   <= '0;
      f_ack_q    <= 1'b0;
      ld_ack_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_mode_q <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      f_data_q   <= '0;
    end else begin
      f_ack_q  <= 1'b0;
      ld_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          mem_we_q   <= 1'b0;
          mem_mode_q <= 1'b0;
          if (grant_f_d) begin
            state_q    <= S_PARK;
            is_wr_q    <= 1'b0;
            tgt_q      <= f_addr;
            starve_q   <= '0;
            mem_addr_q <= park_f_d;
          end else if (grant_ld_d) begin
            state_q    <= S_PARK;
            is_wr_q    <= 1'b1;
            tgt_q      <= ld_addr;
            wdat_q     <= ld_data;
            starve_q   <= starve_ld_d;
            mem_addr_q <= park_ld_d;
          end
        end
        S_PARK: begin
          mem_addr_q <= tgt_q;
          if (is_wr_q) begin
            state_q    <= S_WR;
            mem_we_q   <= 1'b1;
            mem_mode_q <= 1'b1;
            mem_din_q  <= wdat_q;
          end else begin
            state_q <= S_RD;
          end
        end
        S_RD: begin
          // Memory has seen the target address for a full cycle; capture now.
          state_q  <= S_CAP;
          f_ack_q  <= 1'b1;
          f_data_q <= mem_data_out;
        end
        S_CAP: begin
          state_q <= S_IDLE;
        end
        S_WR: begin
          state_q    <= S_DONE;
          mem_we_q   <= 1'b0;
          mem_mode_q <= 1'b0;
          ld_ack_q   <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign f_ack        = f_ack_q;
  assign f_data       = f_data_q;
  assign ld_ack       = ld_ack_q;
  assign busy         = (state_q != S_IDLE);
  assign mem_write_en = mem_we_q;
  assign mem_mode     = mem_mode_q;
  assign mem_address  = mem_addr_q;
  assign mem_data_in  = mem_din_q;

endmodule

// File: tb/tb_imem_access_ctrl.sv
// tb_imem_access_ctrl: directed bench for imem_access_ctrl with an address-event memory and a transaction model.
// Latency: model expands each grant into a fixed 4-slot trace (park, access, ack, idle).
// Backpressure: requesters hold req until their ack, then drop or retarget.
module tb_imem_access_ctrl;

  localparam int STARVE = 4;

  logic        clk;
  logic        rst;
  logic        f_req;
  logic [4:0]  f_addr;
  logic        f_ack;
  logic [31:0] f_data;
  logic        ld_req;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_ack;
  logic        busy;
  logic        mem_write_en;
  logic        mem_mode;
  logic [4:0]  mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  imem_access_ctrl #(.AW(5), .DW(32), .PARK_ADDR(0), .FETCH_STARVE(STARVE)) dut (
    .clk          (clk),
    .rst          (rst),
    .f_req        (f_req),
    .f_addr       (f_addr),
    .f_ack        (f_ack),
    .f_data       (f_data),
    .ld_req       (ld_req),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .ld_ack       (ld_ack),
    .busy         (busy),
    .mem_write_en (mem_write_en),
    .mem_mode     (mem_mode),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  typedef struct packed {
    logic        f_ack;
    logic        ld_ack;
    logic        busy;
    logic        we;
    logic        mode;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] fdata;
  } obs_t;

  int errors = 0;
  int checks = 0;

  logic [31:0] bmem [32];
  logic [31:0] mref [32];
  obs_t        exp_o = '0;
  obs_t        sched [$];

  function automatic logic [31:0] preload(input int i);
    if (i == 0) return 32'h0;
    if (i == 2) return 32'h14080002;
    return 32'hA5A50000 | 32'(i);
  endfunction

  function automatic obs_t mk(input logic fa, input logic la, input logic b, input logic we,
                              input logic mo, input logic [4:0] a, input logic [31:0] di,
                              input logic [31:0] fd);
    obs_t o;
    o.f_ack = fa; o.ld_ack = la; o.busy = b; o.we = we; o.mode = mo;
    o.addr = a; o.din = di; o.fdata = fd;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory that only acts on address events (seen at the falling edge).
  initial begin
    logic [4:0] prev;
    prev = '0;
    mem_data_out = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_address != prev) begin
        prev = mem_address;
        if (mem_write_en && mem_mode) bmem[mem_address] = mem_data_in;
        else mem_data_out = bmem[mem_address];
      end
    end
  end

  // Transaction model: at each free slot arbitrate, then play out 4 cycles.
  initial begin
    logic [4:0]  last_addr;
    logic [31:0] last_din, last_fdata, d;
    logic [4:0]  pa;
    int          starve_m;
    logic        gf, gl;
    last_addr = '0; last_din = '0; last_fdata = '0; starve_m = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        sched.delete();
        exp_o = '0; last_addr = '0; last_din = '0; last_fdata = '0; starve_m = 0;
      end else begin
        if (sched.size() == 0) begin
          gf = f_req && (!ld_req || starve_m == STARVE);
          gl = ld_req && !gf;
          if (gf) begin
            pa = (f_addr == 5'd0) ? 5'd1 : 5'd0;
            d  = mref[f_addr];
            sched.push_back(mk(0, 0, 1, 0, 0, pa, last_din, last_fdata));
            sched.push_back(mk(0, 0, 1, 0, 0, f_addr, last_din, last_fdata));
            sched.push_back(mk(1, 0, 1, 0, 0, f_addr, last_din, d));
            sched.push_back(mk(0, 0, 0, 0, 0, f_addr, last_din, d));
            last_fdata = d; last_addr = f_addr; starve_m = 0;
          end else if (gl) begin
            pa = (ld_addr == 5'd0) ? 5'd1 : 5'd0;
            sched.push_back(mk(0, 0, 1, 0, 0, pa, last_din, last_fdata));
            sched.push_back(mk(0, 0, 1, 1, 1, ld_addr, ld_data, last_fdata));
            sched.push_back(mk(0, 1, 1, 0, 0, ld_addr, ld_data, last_fdata));
            sched.push_back(mk(0, 0, 0, 0, 0, ld_addr, ld_data, last_fdata));
            last_din = ld_data; last_addr = ld_addr;
            starve_m = f_req ? ((starve_m < STARVE) ? starve_m + 1 : STARVE) : 0;
          end
        end
        if (sched.size() != 0) begin
          exp_o = sched.pop_front();
          if (exp_o.we) mref[exp_o.addr] = exp_o.din;
        end else begin
          exp_o = mk(0, 0, 0, 0, 0, last_addr, last_din, last_fdata);
        end
      end
    end
  end

  // Cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("f_ack", 32'(f_ack), 32'(exp_o.f_ack));
      chk("ld_ack", 32'(ld_ack), 32'(exp_o.ld_ack));
      chk("busy", 32'(busy), 32'(exp_o.busy));
      chk("mem_write_en", 32'(mem_write_en), 32'(exp_o.we));
      chk("mem_mode", 32'(mem_mode), 32'(exp_o.mode));
      chk("mem_address", 32'(mem_address), 32'(exp_o.addr));
      chk("f_data", f_data, exp_o.fdata);
      if (exp_o.we || !rst) chk("mem_data_in", mem_data_in, exp_o.din);
    end
  end

  task automatic wait_fetch(output logic [31:0] d, output int lat, output logic [4:0] a0,
                            output logic [4:0] a1);
    lat = -1; d = '0; a0 = '0; a1 = '0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) a0 = mem_address;
      if (n == 2) a1 = mem_address;
      if (f_ack) begin
        lat = n; d = f_data;
        break;
      end
    end
    @(posedge clk);
    #1 f_req = 1'b0;
  endtask

  task automatic do_fetch(input logic [4:0] a, output logic [31:0] d, output int lat,
                          output logic [4:0] a0, output logic [4:0] a1);
    @(posedge clk);
    #1 f_req = 1'b1; f_addr = a;
    wait_fetch(d, lat, a0, a1);
  endtask

  task automatic do_load(input logic [4:0] a, input logic [31:0] d, output int lat, output int wr_n);
    lat = -1; wr_n = -1;
    @(posedge clk);
    #1 ld_req = 1'b1; ld_addr = a; ld_data = d;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_write_en && mem_mode && mem_address == a && mem_data_in == d) wr_n = n;
      if (ld_ack) begin
        lat = n;
        break;
      end
    end
    @(posedge clk);
    #1 ld_req = 1'b0;
  endtask

  initial begin
    logic [31:0] d, fd;
    logic [4:0]  a0, a1;
    int          lat, wr_n, nld, nf, lbefore, nack;
    logic        saw_l, saw_f, seen;

    for (int i = 0; i < 32; i++) begin
      bmem[i] = preload(i);
      mref[i] = preload(i);
    end
    rst = 1'b1; f_req = 1'b1; f_addr = 5'd2; ld_req = 1'b0; ld_addr = '0; ld_data = '0;
    #1 rst = 1'b0;

    // Reset held with a pending fetch.
    repeat (2) @(posedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_f_ack", 32'(f_ack), 32'd0);
    #1 rst = 1'b1;
    wait_fetch(d, lat, a0, a1);
    chk("rst_fetch_lat", 32'(lat), 32'd3);
    chk("fetch2_data", d, 32'h14080002);
    chk("fetch2_park", 32'(a0), 32'd0);
    chk("fetch2_addr", 32'(a1), 32'd2);

    // Target equal to the park address.
    do_fetch(5'd0, d, lat, a0, a1);
    chk("park_lat", 32'(lat), 32'd3);
    chk("park_alt", 32'(a0), 32'd1);
    chk("park_tgt", 32'(a1), 32'd0);
    chk("park_data", d, 32'h0);

    // Load then read back.
    do_load(5'd25, 32'hDEADBEEF, lat, wr_n);
    chk("load_lat", 32'(lat), 32'd3);
    chk("load_wr_cycle", 32'(wr_n), 32'd2);
    do_fetch(5'd25, d, lat, a0, a1);
    chk("readback_25", d, 32'hDEADBEEF);

    // Loader held for 6 writes while fetch waits.
    @(posedge clk);
    #1 f_req = 1'b1; f_addr = 5'd3; ld_req = 1'b1; ld_addr = 5'd10; ld_data = 32'hC0DE0000;
    nld = 0; nf = 0; lbefore = -1; fd = '0;
    for (int n = 0; n < 100 && !(nld == 6 && nf == 1); n++) begin
      @(negedge clk);
      saw_l = ld_ack; saw_f = f_ack;
      if (saw_l) nld++;
      if (saw_f) begin
        nf++; lbefore = nld; fd = f_data;
      end
      @(posedge clk);
      #1;
      if (saw_l) begin
        if (nld < 6) begin
          ld_addr = 5'(10 + nld); ld_data = 32'hC0DE0000 + 32'(nld);
        end else begin
          ld_req = 1'b0;
        end
      end
      if (saw_f) f_req = 1'b0;
    end
    chk("starve_ld_before_f", 32'(lbefore), 32'd4);
    chk("starve_ld_total", 32'(nld), 32'd6);
    chk("starve_f_total", 32'(nf), 32'd1);
    chk("starve_f_data", fd, 32'hA5A50003);
    do_fetch(5'd12, d, lat, a0, a1);
    chk("readback_12", d, 32'hC0DE0002);

    // Reset during the write cycle.
    @(posedge clk);
    #1 ld_req = 1'b1; ld_addr = 5'd9; ld_data = 32'h0BAD0009;
    nack = 0; seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (ld_ack) nack++;
      if (mem_write_en) seen = 1'b1;
    end
    #1 rst = 1'b0; ld_req = 1'b0;
    chk("midwr_seen", 32'(seen), 32'd1);
    #1;
    chk("midwr_we", 32'(mem_write_en), 32'd0);
    chk("midwr_busy", 32'(busy), 32'd0);
    chk("midwr_addr", 32'(mem_address), 32'd0);
    repeat (2) begin
      @(negedge clk);
      if (ld_ack) nack++;
    end
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (ld_ack) nack++;
    end
    chk("midwr_no_ack", 32'(nack), 32'd0);

    do_fetch(5'd2, d, lat, a0, a1);
    chk("recover_lat", 32'(lat), 32'd3);
    chk("recover_data", d, 32'h14080002);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/imem_access_ctrl.md
Name: imem_access_ctrl

Overview:
- Sequencer and arbiter for the 32x32 instruction memory (ins_veda).
- Shares the memory's single port between two requesters: the processor fetch unit (reads) and the program loader (writes).
- Drives the memory's write_en/mode/address/data_in pins with a state machine that guarantees an address change on every access, because the memory only responds to address events.
- Returns read data to the fetch unit with a one-cycle ack.

Parameters:
- AW, 5, memory address width.
- DW, 32, instruction/data width.
- PARK_ADDR, 0, address driven during the park cycle.
- FETCH_STARVE, 4, consecutive loader grants allowed while fetch is pending before fetch is forced.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- f_req  in  1  fetch request; held high until f_ack.
- f_addr  in  AW  fetch address.
- f_ack  out  1  one-cycle pulse; f_data valid in the same cycle.
- f_data  out  DW  fetched instruction, held until the next fetch ack.
- ld_req  in  1  loader write request; held high until ld_ack.
- ld_addr  in  AW  loader write address.
- ld_data  in  DW  loader write data.
- ld_ack  out  1  one-cycle pulse; write complete.
- busy  out  1  high in any state other than IDLE.
- mem_write_en  out  1  to memory write_en.
- mem_mode  out  1  to memory mode.
- mem_address  out  AW  to memory address.
- mem_data_in  out  DW  to memory data_in.
- mem_data_out  in  DW  from memory data_out.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0 (f_ack, ld_ack, busy, mem_write_en, mem_mode, mem_address, mem_data_in, f_data); starve counter=0. Reset mid-access aborts the access and issues no ack.
- States: IDLE, PARK, RD, CAP, WR, DONE.
- Memory pin encoding:
  - Read: write_en=0, mode=0.
  - Silent write: write_en=1, mode=1.
  - write_en=1, mode=0 is never driven.
- IDLE arbitration at each clock edge:
  - If only one requester is active, grant it.
  - If both are active, grant the loader, unless starve counter == FETCH_STARVE; then grant fetch.
  - At grant, latch the target address (and ld_data for writes) internally. Requester inputs are ignored until the next IDLE.
  - No request: stay in IDLE with read encoding; mem_address holds its last value.
- Starve counter:
  - Increments on a loader grant while f_req=1.
  - Clears on any fetch grant, or on a loader grant with f_req=0.
  - Saturates at FETCH_STARVE.
- PARK (1 cycle):
  - mem_address = PARK_ADDR; if target == PARK_ADDR, drive PARK_ADDR^1 instead.
  - Read encoding.
  - Next state: RD for fetch, WR for loader.
- RD (1 cycle): mem_address = target, read encoding. Next: CAP.
- CAP (1 cycle): f_data <= mem_data_out; f_ack=1 in this cycle. Next: IDLE.
- WR (1 cycle): mem_address = target, mem_data_in = latched data, silent-write encoding. Next: DONE.
- DONE (1 cycle): read encoding, ld_ack=1. Next: IDLE.
- Latency:
  - Fetch: f_ack is 3 cycles after the grant edge (PARK, RD, CAP).
  - Loader: ld_ack is 3 cycles after the grant edge (PARK, WR, DONE).
  - Back-to-back accesses: 4 cycles each (including IDLE).
- Outputs are registered; f_ack and ld_ack never assert together.
- busy = (state != IDLE).
- Requester dropping req before its ack: the access still completes and the ack still pulses; the requester must ignore it.
- A request raised in the same cycle as its ack is treated as a new request at the next IDLE.

Test Plan:
- Reset: rst=0 for 2 cycles with f_req=1 -> all outputs 0, no ack. Release -> f_ack 3 cycles after the first grant edge.
- Fetch: f_req=1, f_addr=2 with the preloaded image -> f_ack with f_data={6'd5,5'd0,5'd8,16'd2}. mem_address sequence 0,2; mem_write_en stays 0.
- Park collision: fetch f_addr=0 -> park cycle drives mem_address=1, then 0. f_data=0.
- Load then read back: ld_req with ld_addr=25, ld_data=32'hDEADBEEF -> WR cycle shows write_en=1, mode=1, address=25; ld_ack after 3 cycles. A subsequent fetch of 25 returns 32'hDEADBEEF.
- Starvation: ld_req held high (6 writes) with f_req high from cycle 0 -> exactly 4 ld_acks, then one f_ack, then loader grants resume.
- Reset mid-write: rst=0 during the WR state -> no ld_ack, state IDLE, outputs 0.
